// File: rtl/scsi_port_sm_pkg.sv
// scsi_port_sm_pkg: shared state encoding and hold-timing constants for the WD33C93A port sequencer.
package scsi_port_sm_pkg;
  typedef enum logic [3:0] {
    IDLE, CPU_ACC, CPU_ACK, DRD, DRD_END, DRD_WAIT, DWR, DWR_END, DWR_WAIT
  } state_t;
  localparam int CNT_W = 3;
  localparam int CS_CYCLES_DEF = 3;
  localparam int DMA_CYCLES_DEF = 3;
endpackage

// File: rtl/scsi_hold_counter.sv
// scsi_hold_counter: down-counter timing the strobe holds; reaches zero in the last held cycle.
module scsi_hold_counter
  import scsi_port_sm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next
);
  assign cnt_next = load ? load_val : (cnt != '0 ? cnt - 1'b1 : cnt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt_next;
endmodule

// File: rtl/scsi_port_sm.sv
// scsi_port_sm: Moore sequencer for CPU register access and byte DMA on the WD33C93A peripheral port.
module scsi_port_sm
  import scsi_port_sm_pkg::*;
#(
  parameter int CS_CYCLES  = CS_CYCLES_DEF,
  parameter int DMA_CYCLES = DMA_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RESET_,
  input  logic CPUREQ,
  input  logic RW,
  input  logic AS_,
  input  logic DMADIR,
  input  logic DREQ_,
  input  logic FIFOFULL,
  input  logic FIFOEMPTY,
  input  logic BOEQ3,
  input  logic INCFIFO,
  input  logic DECFIFO,
  output logic SCSI_CS_o,
  output logic RE_o,
  output logic WE_o,
  output logic DACK_o,
  output logic S2CPU_o,
  output logic CPU2S_o,
  output logic S2F_o,
  output logic F2S_o,
  output logic LS2CPU,
  output logic LBYTE_,
  output logic INCBO_o,
  output logic INCNI_o,
  output logic INCNO_o,
  output logic RIFIFO_o,
  output logic RDFIFO_o
);
  state_t state, state_d;
  logic rw_q, rw_d, load, last;
  logic [CNT_W-1:0] cnt, cnt_d, load_val;
  // The counter is reloaded every IDLE cycle so it is primed for whichever hold follows.
  assign load = state == IDLE;
  assign load_val = CPUREQ ? CNT_W'(CS_CYCLES - 1) : CNT_W'(DMA_CYCLES - 1);
  assign rw_d = load ? RW : rw_q;
  assign last = cnt == '0;
  scsi_hold_counter u_hold (
    .clk      (CLK),
    .rst_n    (RESET_),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .cnt_next (cnt_d)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = CPUREQ ? CPU_ACC :
                          (!DREQ_ && DMADIR && !FIFOFULL) ? DRD :
                          (!DREQ_ && !DMADIR && !FIFOEMPTY) ? DWR : IDLE;
      CPU_ACC:  state_d = last ? CPU_ACK : CPU_ACC;
      CPU_ACK:  state_d = AS_ ? IDLE : CPU_ACK;
      DRD:      state_d = last ? DRD_END : DRD;
      DRD_END:  state_d = BOEQ3 ? DRD_WAIT : IDLE;
      DRD_WAIT: state_d = INCFIFO ? IDLE : DRD_WAIT;
      DWR:      state_d = last ? DWR_END : DWR;
      DWR_END:  state_d = BOEQ3 ? DWR_WAIT : IDLE;
      DWR_WAIT: state_d = DECFIFO ? IDLE : DWR_WAIT;
      default:  state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so each register lines up with the state it belongs to.
  always_ff @(posedge CLK or negedge RESET_)
    if (!RESET_) begin
      state     <= IDLE;
      rw_q      <= 1'b0;
      SCSI_CS_o <= 1'b0;
      RE_o      <= 1'b0;
      WE_o      <= 1'b0;
      DACK_o    <= 1'b0;
      S2CPU_o   <= 1'b0;
      CPU2S_o   <= 1'b0;
      S2F_o     <= 1'b0;
      F2S_o     <= 1'b0;
      LS2CPU    <= 1'b1;
      LBYTE_    <= 1'b1;
      INCBO_o   <= 1'b0;
      INCNI_o   <= 1'b0;
      INCNO_o   <= 1'b0;
      RIFIFO_o  <= 1'b0;
      RDFIFO_o  <= 1'b0;
    end else begin
      state     <= state_d;
      rw_q      <= rw_d;
      SCSI_CS_o <= state_d == CPU_ACC;
      RE_o      <= (state_d == CPU_ACC && rw_d) || state_d == DRD;
      WE_o      <= (state_d == CPU_ACC && !rw_d) || state_d == DWR;
      DACK_o    <= state_d == DRD || state_d == DWR;
      S2CPU_o   <= (state_d == CPU_ACC || state_d == CPU_ACK) && rw_d;
      CPU2S_o   <= (state_d == CPU_ACC || state_d == CPU_ACK) && !rw_d;
      S2F_o     <= state_d == DRD;
      F2S_o     <= state_d == DWR;
      LS2CPU    <= state_d != CPU_ACK;
      LBYTE_    <= !(state_d == DRD && cnt_d == '0);
      INCBO_o   <= state_d == DRD_END || state_d == DWR_END;
      INCNI_o   <= state == DRD_WAIT && INCFIFO;
      INCNO_o   <= state == DWR_WAIT && DECFIFO;
      RIFIFO_o  <= state_d == DRD_WAIT;
      RDFIFO_o  <= state_d == DWR_WAIT;
    end
endmodule

// File: tb/tb_scsi_port_sm.sv
// tb_scsi_port_sm: directed and random stimulus checked each cycle against a queue-scripted transaction model.
module tb_scsi_port_sm;
  localparam int CS = 3;
  localparam int DMA = 3;
  localparam logic [14:0] V_CS = 15'h4000, V_RE = 15'h2000, V_WE = 15'h1000, V_DACK = 15'h0800;
  localparam logic [14:0] V_S2CPU = 15'h0400, V_CPU2S = 15'h0200, V_S2F = 15'h0100, V_F2S = 15'h0080;
  localparam logic [14:0] V_LS = 15'h0040, V_LB = 15'h0020, V_INCBO = 15'h0010, V_INCNI = 15'h0008;
  localparam logic [14:0] V_INCNO = 15'h0004, V_RIF = 15'h0002, V_RDF = 15'h0001;
  localparam logic [14:0] IDLE_V = V_LS | V_LB;
  localparam int P_IDLE = 0, P_ACK = 1, P_RD = 2, P_WR = 3, P_INC = 4, P_DEC = 5;
  logic CLK = 1'b0, RESET_ = 1'b0;
  logic CPUREQ = 1'b0, RW = 1'b0, AS_ = 1'b1, DMADIR = 1'b0, DREQ_ = 1'b1;
  logic FIFOFULL = 1'b0, FIFOEMPTY = 1'b0, BOEQ3 = 1'b0, INCFIFO = 1'b0, DECFIFO = 1'b0;
  logic SCSI_CS_o, RE_o, WE_o, DACK_o, S2CPU_o, CPU2S_o, S2F_o, F2S_o;
  logic LS2CPU, LBYTE_, INCBO_o, INCNI_o, INCNO_o, RIFIFO_o, RDFIFO_o;
  logic [14:0] outs, exp_v;
  logic [14:0] q[$];
  int pend = P_IDLE;
  logic mrw = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int n, nb, nd, nl;
  scsi_port_sm #(.CS_CYCLES(CS), .DMA_CYCLES(DMA)) dut (
    .CLK(CLK), .RESET_(RESET_), .CPUREQ(CPUREQ), .RW(RW), .AS_(AS_), .DMADIR(DMADIR),
    .DREQ_(DREQ_), .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY), .BOEQ3(BOEQ3),
    .INCFIFO(INCFIFO), .DECFIFO(DECFIFO), .SCSI_CS_o(SCSI_CS_o), .RE_o(RE_o), .WE_o(WE_o),
    .DACK_o(DACK_o), .S2CPU_o(S2CPU_o), .CPU2S_o(CPU2S_o), .S2F_o(S2F_o), .F2S_o(F2S_o),
    .LS2CPU(LS2CPU), .LBYTE_(LBYTE_), .INCBO_o(INCBO_o), .INCNI_o(INCNI_o), .INCNO_o(INCNO_o),
    .RIFIFO_o(RIFIFO_o), .RDFIFO_o(RDFIFO_o)
  );
  assign outs = {SCSI_CS_o, RE_o, WE_o, DACK_o, S2CPU_o, CPU2S_o, S2F_o, F2S_o,
                 LS2CPU, LBYTE_, INCBO_o, INCNI_o, INCNO_o, RIFIFO_o, RDFIFO_o};
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask
  // Each accepted operation is scripted as the full list of per-cycle output vectors it will produce;
  // only the open-ended waits are resolved cycle by cycle from the inputs.
  function automatic void model_step();
    if (q.size() == 0)
      case (pend)
        P_IDLE:
          if (CPUREQ) begin
            mrw = RW;
            repeat (CS) q.push_back(V_CS | IDLE_V | (RW ? (V_RE | V_S2CPU) : (V_WE | V_CPU2S)));
            q.push_back(V_LB | (RW ? V_S2CPU : V_CPU2S));
            pend = P_ACK;
          end else if (!DREQ_ && DMADIR && !FIFOFULL) begin
            for (int i = 0; i < DMA; i++) q.push_back(V_DACK | V_RE | V_S2F | V_LS | (i == DMA - 1 ? 15'h0 : V_LB));
            q.push_back(IDLE_V | V_INCBO);
            pend = P_RD;
          end else if (!DREQ_ && !DMADIR && !FIFOEMPTY) begin
            repeat (DMA) q.push_back(V_DACK | V_WE | V_F2S | IDLE_V);
            q.push_back(IDLE_V | V_INCBO);
            pend = P_WR;
          end else q.push_back(IDLE_V);
        P_ACK: begin
          q.push_back(AS_ ? IDLE_V : (V_LB | (mrw ? V_S2CPU : V_CPU2S)));
          if (AS_) pend = P_IDLE;
        end
        P_RD: begin
          q.push_back(BOEQ3 ? (IDLE_V | V_RIF) : IDLE_V);
          pend = BOEQ3 ? P_INC : P_IDLE;
        end
        P_WR: begin
          q.push_back(BOEQ3 ? (IDLE_V | V_RDF) : IDLE_V);
          pend = BOEQ3 ? P_DEC : P_IDLE;
        end
        P_INC: begin
          q.push_back(INCFIFO ? (IDLE_V | V_INCNI) : (IDLE_V | V_RIF));
          if (INCFIFO) pend = P_IDLE;
        end
        default: begin
          q.push_back(DECFIFO ? (IDLE_V | V_INCNO) : (IDLE_V | V_RDF));
          if (DECFIFO) pend = P_IDLE;
        end
      endcase
    exp_v = q.pop_front();
  endfunction
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    chk("cycle", outs, exp_v);
  endtask
  task automatic model_reset();
    q.delete();
    pend = P_IDLE;
  endtask
  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("reset", outs, IDLE_V);
    RESET_ = 1'b1;
    model_reset();
    CPUREQ = 1'b1; RW = 1'b1; AS_ = 1'b0; n = 0;
    tick();
    n += SCSI_CS_o;
    chk("rd_strobes", {RE_o, S2CPU_o}, 2'b11);
    CPUREQ = 1'b0;
    repeat (5) begin tick(); n += SCSI_CS_o; end
    chk("rd_cs_cycles", n, CS);
    chk("rd_ls2cpu_low", LS2CPU, 1'b0);
    AS_ = 1'b1;
    tick();
    chk("rd_back_idle", {LS2CPU, S2CPU_o}, 2'b10);
    CPUREQ = 1'b1; RW = 1'b0; AS_ = 1'b0; DMADIR = 1'b1; DREQ_ = 1'b0;
    tick();
    chk("cpu_wins", {WE_o, CPU2S_o, DACK_o, RE_o}, 4'b1100);
    CPUREQ = 1'b0;
    repeat (3) tick();
    AS_ = 1'b1;
    tick();
    tick();
    chk("dma_after_cpu", {DACK_o, RE_o, S2F_o}, 3'b111);
    DREQ_ = 1'b1;
    repeat (4) tick();
    DREQ_ = 1'b0; nb = 0; nd = 0; nl = 0;
    for (int i = 0; i < 40 && nb < 4; i++) begin
      tick();
      nb += INCBO_o; nd += DACK_o; nl += !LBYTE_;
    end
    BOEQ3 = 1'b1; DREQ_ = 1'b1;
    tick();
    chk("word_bytes", nb, 4);
    chk("word_dack_cycles", nd, 4 * DMA);
    chk("word_lbyte_cycles", nl, 4);
    chk("rififo_held", RIFIFO_o, 1'b1);
    tick();
    INCFIFO = 1'b1;
    tick();
    chk("incni_pulse", {INCNI_o, RIFIFO_o}, 2'b10);
    INCFIFO = 1'b0; BOEQ3 = 1'b0;
    tick();
    chk("incni_single", INCNI_o, 1'b0);
    DMADIR = 1'b0; DREQ_ = 1'b0; FIFOEMPTY = 1'b1;
    repeat (3) tick();
    chk("empty_no_dack", DACK_o, 1'b0);
    FIFOEMPTY = 1'b0;
    tick();
    chk("dwr_start", {DACK_o, WE_o, F2S_o}, 3'b111);
    DREQ_ = 1'b1; BOEQ3 = 1'b1;
    repeat (3) tick();
    chk("dwr_incbo", INCBO_o, 1'b1);
    n = 0;
    repeat (5) begin tick(); n += RDFIFO_o; end
    chk("rdfifo_cycles", n, 5);
    DECFIFO = 1'b1;
    tick();
    chk("incno_pulse", {INCNO_o, RDFIFO_o}, 2'b10);
    tick();
    chk("stray_decfifo", outs, IDLE_V);
    DECFIFO = 1'b0; BOEQ3 = 1'b0; DMADIR = 1'b1; DREQ_ = 1'b0;
    tick();
    chk("pre_reset_drd", DACK_o, 1'b1);
    RESET_ = 1'b0;
    #1;
    chk("async_reset", outs, IDLE_V);
    @(posedge CLK);
    #1;
    RESET_ = 1'b1; DREQ_ = 1'b1;
    model_reset();
    tick();
    for (int i = 0; i < 3000; i++) begin
      CPUREQ = $urandom_range(7) == 0;
      RW = $urandom_range(1) == 1;
      AS_ = $urandom_range(2) == 0;
      DMADIR = $urandom_range(1) == 1;
      DREQ_ = $urandom_range(1) == 1;
      FIFOFULL = $urandom_range(3) == 0;
      FIFOEMPTY = $urandom_range(3) == 0;
      BOEQ3 = $urandom_range(2) == 0;
      INCFIFO = $urandom_range(3) == 0;
      DECFIFO = $urandom_range(3) == 0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scsi_port_sm.md
Name: scsi_port_sm

Overview:
- Sequencer for the 16-bit peripheral port to the WD33C93A SCSI controller inside the SCSI DMA controller.
- Runs CPU register accesses to the WD33C93A: CPU-to-SCSI writes and SCSI-to-CPU reads with acknowledge.
- Runs byte DMA in both directions between the SCSI chip and the 32-bit FIFO: SCSI-to-FIFO and FIFO-to-SCSI.
- Sits between the register block, the CPU bus-master state machine and the FIFO/datapath.

Parameters:
- CS_CYCLES, 3, CLK cycles that the chip select/strobe is held for a CPU register access (range 2..7).
- DMA_CYCLES, 3, CLK cycles that DACK/strobe is held per DMA byte (range 2..7).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET_  in  1  asynchronous active-low reset.
- CPUREQ  in  1  CPU access to a WD33C93A register is pending.
- RW  in  1  CPU direction: 1 = read, 0 = write.
- AS_  in  1  CPU address strobe, active low.
- DMADIR  in  1  1 = SCSI to memory (fill FIFO), 0 = memory to SCSI (drain FIFO).
- DREQ_  in  1  SCSI DMA request, active low, already gated by DMA enable.
- FIFOFULL  in  1  FIFO full.
- FIFOEMPTY  in  1  FIFO empty.
- BOEQ3  in  1  FIFO byte offset equals 3 (last byte of the word).
- INCFIFO  in  1  FIFO write-pointer advance done.
- DECFIFO  in  1  FIFO read-pointer advance done.
- SCSI_CS_o, RE_o, WE_o, DACK_o  out  1 each  port strobes, active high.
- S2CPU_o, CPU2S_o, S2F_o, F2S_o  out  1 each  datapath steering.
- LS2CPU  out  1  low = latch SCSI data and acknowledge the CPU; idle high.
- LBYTE_  out  1  low = latch port byte into the FIFO; idle high.
- INCBO_o, INCNI_o, INCNO_o  out  1 each  one-cycle pulses: advance byte offset, next-in pointer, next-out pointer.
- RIFIFO_o, RDFIFO_o  out  1 each  request FIFO increment / decrement; held until acknowledged.

Behaviour:
- Moore FSM. All outputs are registered and decoded from the state.
- Reset values: state IDLE; LS2CPU=1 and LBYTE_=1; every other output 0.
- Reset asserted mid-operation aborts immediately to IDLE.
- IDLE priority order:
  - CPUREQ=1 goes to CPU_ACC.
  - Otherwise, DREQ_=0 and DMADIR=1 and FIFOFULL=0 goes to DRD.
  - Otherwise, DREQ_=0 and DMADIR=0 and FIFOEMPTY=0 goes to DWR.
- A DMA byte in progress is never pre-empted. CPUREQ is served from the next IDLE.
- CPU_ACC, held CS_CYCLES cycles:
  - SCSI_CS_o=1.
  - RW=1: RE_o=1 and S2CPU_o=1.
  - RW=0: WE_o=1 and CPU2S_o=1.
  - Then go to CPU_ACK.
- CPU_ACK:
  - SCSI_CS_o=0, RE_o=0, WE_o=0.
  - S2CPU_o or CPU2S_o is held.
  - LS2CPU=0 until AS_=1, then IDLE.
  - If AS_ is already 1 on entry, hold CPU_ACK for one cycle.
- DRD, held DMA_CYCLES cycles:
  - DACK_o=1, RE_o=1, S2F_o=1.
  - LBYTE_=0 in the last cycle.
  - Then go to DRD_END.
- DRD_END, one cycle:
  - INCBO_o pulses.
  - If BOEQ3=1 (sampled here), go to DRD_WAIT; otherwise go to IDLE.
- DRD_WAIT:
  - RIFIFO_o=1 until INCFIFO=1.
  - In the cycle INCFIFO=1 is seen: INCNI_o pulses and the FSM goes to IDLE.
- DWR, held DMA_CYCLES cycles:
  - DACK_o=1, WE_o=1, F2S_o=1.
  - Then go to DWR_END.
- DWR_END, one cycle:
  - INCBO_o pulses.
  - If BOEQ3=1, go to DWR_WAIT; otherwise go to IDLE.
- DWR_WAIT:
  - RDFIFO_o=1 until DECFIFO=1.
  - In the cycle DECFIFO=1 is seen: INCNO_o pulses and the FSM goes to IDLE.
- RE_o and WE_o are never 1 together.
- DACK_o and SCSI_CS_o are never 1 together.
- FIFOFULL, FIFOEMPTY and DREQ_ are sampled only in IDLE.
- DMADIR changing mid-transfer has no effect until IDLE.
- Stray INCFIFO/DECFIFO pulses outside the WAIT states are ignored.

Decomposition:
- Shared package holds the state enum (IDLE, CPU_ACC, CPU_ACK, DRD, DRD_END, DRD_WAIT, DWR, DWR_END, DWR_WAIT) and the cycle-count constants.
- One sub-module is natural: scsi_hold_counter, a small down-counter that times the CPU_ACC, DRD and DWR holds.

Test Plan:
- Reset: RESET_=0 asynchronously in DRD → all outputs reach reset values without a clock edge: LS2CPU=1, LBYTE_=1, rest 0.
- CPU read: CPUREQ=1, RW=1, AS_=0 → SCSI_CS_o=RE_o=S2CPU_o=1 for 3 cycles, then LS2CPU=0 until AS_=1; IDLE one cycle after AS_ rises.
- CPU write over DMA: CPUREQ=1, RW=0 and DREQ_=0 in the same IDLE cycle → CPU_ACC wins; WE_o=CPU2S_o=1 for 3 cycles; DMA starts after the access ends.
- SCSI-to-FIFO word: DMADIR=1, DREQ_=0, FIFOFULL=0, four bytes with BOEQ3=1 on the fourth →
  - four bursts of DACK_o=RE_o=S2F_o=1 (3 cycles each) with LBYTE_ low in the third cycle;
  - four INCBO_o pulses;
  - then RIFIFO_o held; INCFIFO=1 after 2 cycles → one INCNI_o pulse, IDLE.
- FIFO-to-SCSI with empty FIFO: DMADIR=0, DREQ_=0, FIFOEMPTY=1 → stays IDLE, DACK_o=0. Clearing FIFOEMPTY starts DWR the next cycle.
- DWR_WAIT: BOEQ3=1 → RDFIFO_o stays 1 for 5 cycles until DECFIFO=1 → INCNO_o pulses once. A stray DECFIFO pulse in IDLE produces no output.
